// File: rtl/mtf_cpg_pkg.sv
// -----------------------------------------------------------------------------
// mtf_cpg_pkg
// Shared definitions for the CPG neuron scheduler:
//   - default neuron count and drive/weight width
//   - scheduler FSM state encoding
//   - index/address field width helper
//   - signed saturation helper used on the coupling accumulator output
// -----------------------------------------------------------------------------
package mtf_cpg_pkg;

    localparam int N_NEURON_DEF = 4;
    localparam int W_DEF        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUM,
        ST_ISSUE,
        ST_WAIT,
        ST_COMMIT
    } state_t;

    // Width of a neuron index field; the config address is two of these {k, j}.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a signed value into the w-bit two's complement range.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mtf_cpg_coupling_acc.sv
// -----------------------------------------------------------------------------
// mtf_cpg_coupling_acc
// Drive accumulator for one neuron context. Loads the sign-extended base drive,
// conditionally adds one coupling weight per cycle, and presents the running
// sum saturated back to W bits. The accumulator carries log2(N_NEURON)+1 guard
// bits so summing base plus N_NEURON-1 weights can never wrap.
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   i_load      load i_base (takes priority over i_add)
//   i_base      signed base drive, W bits
//   i_add       add i_weight to the accumulator
//   i_weight    signed coupling weight, W bits
//   o_sat       accumulator saturated to the signed W-bit range
// -----------------------------------------------------------------------------
module mtf_cpg_coupling_acc
    import mtf_cpg_pkg::*;
#(
    parameter int N_NEURON = N_NEURON_DEF,
    parameter int W        = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_base,
    input  logic         i_add,
    input  logic [W-1:0] i_weight,
    output logic [W-1:0] o_sat
);

    localparam int AW = W + idx_w(N_NEURON) + 1;

    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_base_x;
    logic signed [AW-1:0] w_weight_x;
    logic signed [31:0]   w_acc32;

    assign w_base_x   = {{(AW-W){i_base[W-1]}}, i_base};
    assign w_weight_x = {{(AW-W){i_weight[W-1]}}, i_weight};
    assign w_acc32    = {{(32-AW){r_acc[AW-1]}}, r_acc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_base_x;
        end else if (i_add) begin
            r_acc <= r_acc + w_weight_x;
        end
    end

    assign o_sat = W'(saturate(w_acc32, W));

endmodule

// File: rtl/mtf_cpg_scheduler.sv
// -----------------------------------------------------------------------------
// mtf_cpg_scheduler
// Shares one MTF neuron update engine among N_NEURON CPG neuron contexts.
// Each tick runs one sweep: for every neuron k in order, accumulate base[k]
// plus w[k][j] for every other neuron j that spiked in the previous sweep,
// issue one saturated drive to the engine, collect its spike, and at the end
// commit the whole new spike vector at once (Jacobi update).
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   tick           one-cycle sweep request (dropped + flagged while busy)
//   cfg_we/addr/data  config RAM write, addr = {k, j}; j == k selects base[k]
//   clr_err        clears the sticky error flags (a new error wins)
//   eng_start      one-cycle engine request
//   eng_idx        neuron context being updated
//   eng_i_ext      saturated drive, held until eng_done
//   eng_done       engine completion (ignored outside WAIT)
//   eng_spike      engine spike result, valid with eng_done
//   spikes         committed spike vector of the last completed sweep
//   sweep_done     one-cycle pulse in the commit cycle
//   busy           high from tick acceptance through commit
//   tick_overrun   sticky: tick while busy
//   cfg_reject     sticky: cfg_we while busy
// -----------------------------------------------------------------------------
module mtf_cpg_scheduler
    import mtf_cpg_pkg::*;
#(
    parameter int N_NEURON = N_NEURON_DEF,
    parameter int W        = W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    input  logic                           cfg_we,
    input  logic [2*idx_w(N_NEURON)-1:0]   cfg_addr,
    input  logic [W-1:0]                   cfg_data,
    input  logic                           clr_err,
    output logic                           eng_start,
    output logic [idx_w(N_NEURON)-1:0]     eng_idx,
    output logic [W-1:0]                   eng_i_ext,
    input  logic                           eng_done,
    input  logic                           eng_spike,
    output logic [N_NEURON-1:0]            spikes,
    output logic                           sweep_done,
    output logic                           busy,
    output logic                           tick_overrun,
    output logic                           cfg_reject
);

    localparam int            IW   = idx_w(N_NEURON);
    localparam int            NCFG = N_NEURON * N_NEURON;
    localparam logic [IW-1:0] LAST = IW'(N_NEURON - 1);

    state_t              r_state;
    state_t              w_next;
    logic [IW-1:0]       r_k;
    logic [IW-1:0]       r_j;
    logic [N_NEURON-1:0] r_spikes;
    logic [N_NEURON-1:0] r_new_spk;
    logic                r_tick_ovr;
    logic                r_cfg_rej;
    logic [W-1:0]        r_cfg [NCFG];

    logic                w_acc_load;
    logic                w_acc_add;
    logic [IW-1:0]       w_ld_k;
    logic [W-1:0]        w_base;
    logic [W-1:0]        w_weight;
    logic [W-1:0]        w_sat;
    logic                w_busy;
    logic                w_cfg_ok;
    logic                w_cfg_err;
    logic                w_tick_err;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_cfg_ok   = cfg_we & ~w_busy;
    assign w_cfg_err  = cfg_we & w_busy;
    assign w_tick_err = tick & w_busy;

    // Base of the neuron about to be loaded (0 on tick, k+1 on engine done);
    // weight of the source currently being summed.
    assign w_base   = r_cfg[{w_ld_k, w_ld_k}];
    assign w_weight = r_cfg[{r_k, r_j}];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        w_next     = r_state;
        w_acc_load = 1'b0;
        w_acc_add  = 1'b0;
        w_ld_k     = '0;
        eng_start  = 1'b0;
        sweep_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tick) begin
                    w_next     = ST_SUM;
                    w_acc_load = 1'b1;
                end
            end
            ST_SUM: begin
                // Diagonal is the base term, already loaded; coupling reads
                // only the committed spike vector.
                w_acc_add = (r_j != r_k) && r_spikes[r_j];
                if (r_j == LAST) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_start = 1'b1;
                w_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    if (r_k == LAST) begin
                        w_next = ST_COMMIT;
                    end else begin
                        w_next     = ST_SUM;
                        w_acc_load = 1'b1;
                        w_ld_k     = r_k + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                sweep_done = 1'b1;
                w_next     = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Sweep counters, spike vectors, config RAM and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k        <= '0;
            r_j        <= '0;
            r_spikes   <= '0;
            r_new_spk  <= '0;
            r_tick_ovr <= 1'b0;
            r_cfg_rej  <= 1'b0;
            for (int i = 0; i < NCFG; i++) begin
                r_cfg[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tick) begin
                        r_k       <= '0;
                        r_j       <= '0;
                        r_new_spk <= '0;
                    end
                end
                ST_SUM: begin
                    // N_NEURON is a power of two, so j wraps back to 0 for
                    // the next neuron on its own.
                    r_j <= r_j + 1'b1;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        r_new_spk[r_k] <= eng_spike;
                        if (r_k != LAST) begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_spikes <= r_new_spk;
                end
                default: begin
                end
            endcase

            if (w_cfg_ok) begin
                r_cfg[cfg_addr] <= cfg_data;
            end

            // A new error event overrides a coincident clear.
            r_tick_ovr <= w_tick_err | (r_tick_ovr & ~clr_err);
            r_cfg_rej  <= w_cfg_err  | (r_cfg_rej  & ~clr_err);
        end
    end

    mtf_cpg_coupling_acc #(
        .N_NEURON (N_NEURON),
        .W        (W)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_acc_load),
        .i_base   (w_base),
        .i_add    (w_acc_add),
        .i_weight (w_weight),
        .o_sat    (w_sat)
    );

    assign eng_idx      = r_k;
    assign eng_i_ext    = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) ? w_sat : '0;
    assign spikes       = r_spikes;
    assign busy         = w_busy;
    assign tick_overrun = r_tick_ovr;
    assign cfg_reject   = r_cfg_rej;

endmodule

// File: tb/tb_mtf_cpg_scheduler.sv
module tb_mtf_cpg_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       clr_err = 1'b0;
    logic       eng_start;
    logic [1:0] eng_idx;
    logic [7:0] eng_i_ext;
    logic       eng_done = 1'b0;
    logic       eng_spike = 1'b0;
    logic [3:0] spikes;
    logic       sweep_done;
    logic       busy;
    logic       tick_overrun;
    logic       cfg_reject;

    mtf_cpg_scheduler #(.N_NEURON(N), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .clr_err      (clr_err),
        .eng_start    (eng_start),
        .eng_idx      (eng_idx),
        .eng_i_ext    (eng_i_ext),
        .eng_done     (eng_done),
        .eng_spike    (eng_spike),
        .spikes       (spikes),
        .sweep_done   (sweep_done),
        .busy         (busy),
        .tick_overrun (tick_overrun),
        .cfg_reject   (cfg_reject)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int         cfg_m [N][N];
    logic [3:0] model_spk = '0;
    logic [3:0] eng_spk_pat = '0;
    int         eng_lat = 3;

    typedef struct {
        int         idx;
        logic [7:0] drv;
    } exp_t;
    exp_t exp_q[$];

    int         eng_cnt = 0;
    int         eng_pidx = 0;
    logic [7:0] eng_pdrv = '0;

    function automatic logic [7:0] exp_drive(input int k);
        int acc;
        acc = cfg_m[k][k];
        for (int j = 0; j < N; j++) begin
            if (j != k && model_spk[j]) acc += cfg_m[k][j];
        end
        if (acc > 127) acc = 127;
        else if (acc < -128) acc = -128;
        return 8'(acc);
    endfunction

    // Engine model: answers each eng_start after eng_lat cycles with the
    // spike chosen by eng_spk_pat; checks the issued drive against the
    // scoreboard and its stability at completion.
    always begin
        exp_t e;
        @(posedge clk); #1;
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) begin
                eng_done  = 1'b1;
                eng_spike = eng_spk_pat[eng_pidx];
                if (busy === 1'b1) begin
                    n_checks++;
                    if (eng_idx !== 2'(eng_pidx) || eng_i_ext !== eng_pdrv) begin
                        n_fail++;
                        $display("FAIL hold_stable: idx=%0d ext=%0d required idx=%0d ext=%0d",
                                 eng_idx, $signed(eng_i_ext), eng_pidx, $signed(eng_pdrv));
                    end
                end
            end
        end
        if (eng_start === 1'b1 && reset === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: eng_start idx=%0d ext=%0d with nothing expected",
                         eng_idx, $signed(eng_i_ext));
                eng_pidx = int'(eng_idx);
                eng_pdrv = eng_i_ext;
            end else begin
                e = exp_q.pop_front();
                if (eng_idx !== 2'(e.idx) || eng_i_ext !== e.drv) begin
                    n_fail++;
                    $display("FAIL eng_issue: idx=%0d ext=%0d required idx=%0d ext=%0d",
                             eng_idx, $signed(eng_i_ext), e.idx, $signed(e.drv));
                end
                eng_pidx = e.idx;
                eng_pdrv = e.drv;
            end
            eng_cnt = eng_lat;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input int k, input int j, input int val);
        cfg_we   = 1'b1;
        cfg_addr = {2'(k), 2'(j)};
        cfg_data = 8'(val);
        step();
        cfg_we = 1'b0;
        cfg_m[k][j] = val;
    endtask

    task automatic push_expect();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.idx = k;
            e.drv = exp_drive(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_sweep(input bit inj_mid, input bit inj_done, input string name);
        int         cyc;
        int         lim;
        logic [3:0] exp_spk;
        push_expect();
        exp_spk = eng_spk_pat;
        lim = 1 + N * (N + 1 + eng_lat) + 1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        cyc = 2;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_rise: busy=%b required 1", name, busy);
        end
        while (sweep_done !== 1'b1 && cyc < lim + 20) begin
            step();
            cyc++;
            tick = 1'b0; cfg_we = 1'b0; clr_err = 1'b0;
            if (inj_mid) begin
                if (cyc == 5) begin
                    tick = 1'b1; cfg_we = 1'b1; cfg_addr = 4'h0; cfg_data = 8'd55;
                end
                if (cyc == 7) begin
                    n_checks++;
                    if (tick_overrun !== 1'b1 || cfg_reject !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s_flags_set: ovr=%b rej=%b required 1 1",
                                 name, tick_overrun, cfg_reject);
                    end
                end
                if (cyc == 8) begin
                    tick = 1'b1; clr_err = 1'b1;
                end
            end
        end
        n_checks++;
        if (sweep_done !== 1'b1 || cyc != lim) begin
            n_fail++;
            $display("FAIL %s_latency: sweep_done=%b at cycle %0d required cycle %0d",
                     name, sweep_done, cyc, lim);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_commit: busy=%b required 1", name, busy);
        end
        if (inj_done) tick = 1'b1;
        step();
        tick = 1'b0;
        n_checks++;
        if (spikes !== exp_spk || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_commit: spikes=%b busy=%b required spikes=%b busy=0",
                     name, spikes, busy, exp_spk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_sb_left: %0d issues missing required 0", name, exp_q.size());
        end
        exp_q.delete();
        if (inj_done) begin
            n_checks++;
            if (tick_overrun !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_tick_at_done: ovr=%b required 1", name, tick_overrun);
            end
        end
        model_spk = exp_spk;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({eng_start, eng_idx, eng_i_ext, spikes, sweep_done, busy, tick_overrun, cfg_reject} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_values: start=%b idx=%0d ext=%0d spk=%b done=%b busy=%b ovr=%b rej=%b required all 0",
                     eng_start, eng_idx, eng_i_ext, spikes, sweep_done, busy, tick_overrun, cfg_reject);
        end
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || eng_start !== 1'b0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b start=%b done=%b required 0 0 0",
                     busy, eng_start, sweep_done);
        end
    endtask

    task automatic test_zero_sweep();
        eng_lat = 3;
        eng_spk_pat = 4'b0000;
        run_sweep(1'b0, 1'b0, "zero");
    endtask

    task automatic test_coupling();
        cfg_write(0, 0, 10);
        cfg_write(0, 1, -5);
        cfg_write(2, 1, 7);
        eng_spk_pat = 4'b0010;
        run_sweep(1'b0, 1'b0, "jacobi");
        eng_spk_pat = 4'b0000;
        run_sweep(1'b0, 1'b0, "couple_on");
        run_sweep(1'b0, 1'b0, "couple_off");
    endtask

    task automatic test_saturation();
        cfg_write(2, 2, 100);
        cfg_write(2, 0, 50);
        cfg_write(2, 1, 50);
        cfg_write(2, 3, 50);
        eng_spk_pat = 4'b1011;
        run_sweep(1'b0, 1'b0, "sat_prep");
        run_sweep(1'b0, 1'b0, "sat_pos");
        for (int j = 0; j < N; j++) cfg_write(2, j, -100);
        run_sweep(1'b0, 1'b0, "sat_neg");
    endtask

    task automatic test_errors();
        eng_spk_pat = 4'b0101;
        run_sweep(1'b1, 1'b0, "err_mid");
        n_checks++;
        if (tick_overrun !== 1'b1 || cfg_reject !== 1'b0) begin
            n_fail++;
            $display("FAIL err_priority: ovr=%b rej=%b required 1 0", tick_overrun, cfg_reject);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_checks++;
        if (tick_overrun !== 1'b0 || cfg_reject !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: ovr=%b rej=%b required 0 0", tick_overrun, cfg_reject);
        end
        // base[0] must still be 10: the rejected write of 55 is not in the model.
        run_sweep(1'b0, 1'b1, "err_done");
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic test_back_to_back();
        eng_lat = 1;
        eng_spk_pat = 4'b0100;
        run_sweep(1'b0, 1'b0, "b2b_a");
        eng_spk_pat = 4'b0001;
        run_sweep(1'b0, 1'b0, "b2b_b");
        eng_lat = 3;
    endtask

    task automatic test_reset_mid();
        int guard;
        eng_spk_pat = 4'b1111;
        push_expect();
        tick = 1'b1;
        step();
        tick = 1'b0;
        guard = 0;
        while (!(eng_start === 1'b1 && eng_idx === 2'd2) && guard < 100) begin
            step();
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL rst_mid_reach: never issued k=2 within %0d cycles", guard);
        end
        step();
        n_checks++;
        if (spikes !== model_spk || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: spikes=%b busy=%b required spikes=%b busy=1",
                     spikes, busy, model_spk);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({eng_start, eng_idx, eng_i_ext, spikes, sweep_done, busy, tick_overrun, cfg_reject} !== 19'd0) begin
            n_fail++;
            $display("FAIL rst_mid_values: start=%b idx=%0d ext=%0d spk=%b done=%b busy=%b required all 0",
                     eng_start, eng_idx, eng_i_ext, spikes, sweep_done, busy);
        end
        exp_q.delete();
        step();
        reset = 1'b0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++) cfg_m[k][j] = 0;
        model_spk = 4'b0000;
        // The engine's late completion arrives now, with the DUT idle.
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (busy !== 1'b0 || spikes !== 4'b0000 || eng_start !== 1'b0 || sweep_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_late_done: busy=%b spikes=%b start=%b done=%b required 0 0000 0 0",
                         busy, spikes, eng_start, sweep_done);
            end
        end
        cfg_write(1, 1, -3);
        eng_spk_pat = 4'b0000;
        run_sweep(1'b0, 1'b0, "post_rst");
    endtask

    initial begin
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++) cfg_m[k][j] = 0;
        test_reset();
        test_zero_sweep();
        test_coupling();
        test_saturation();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
